// File: rtl/lc3_io_pkg.sv
// rtl/lc3_io_pkg.sv - shared LC-3 memory-mapped I/O addresses, DSR bit indices and tx state encoding
package lc3_io_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam int READY_BIT = 15;
    localparam int IE_BIT    = 14;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/lc3_display_tx_uart_tx_core.sv
// rtl/lc3_display_tx_uart_tx_core.sv - 8N1 serialiser: baud counter, shifter and frame FSM
module uart_tx_core
    import lc3_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    // CLKS_PER_BIT must be at least 2 so the baud counter has at least one bit.
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_MAX);
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;

    // State and datapath registers; reset abandons any frame and parks tx high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx is registered so the line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    done    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lc3_display_tx.sv
// rtl/lc3_display_tx.sv - LC-3 display device (DSR/DDR) with UART output; LC3_DISPLAY_IE_EN enables IE/irq
module lc3_display_tx
    import lc3_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              tx,
    output logic              irq
);

    logic       dsr_hit;
    logic       ddr_hit;
    logic       accept;
    logic       done;
    logic       busy;
    logic       ready;
    logic       ie;
    logic [7:0] ddr_byte;
    logic       unused_wdata_hi;

    assign dsr_hit = (addr == DSR_ADDR);
    assign ddr_hit = (addr == DDR_ADDR);
    // ready is sampled before its own update, so a write on the edge ready rises is dropped.
    assign accept  = wr_en & ddr_hit & ready & ~busy;

    assign unused_wdata_hi = ^wdata[DATA_W-1:8];

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .data  (wdata[7:0]),
        .busy  (busy),
        .done  (done),
        .tx    (tx)
    );

    // ready drops on an accepted DDR write and returns on the final stop-bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
        end else if (accept) begin
            ready <= 1'b0;
        end else if (done) begin
            ready <= 1'b1;
        end
    end

    // DDR holds the last accepted byte; writes while busy leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddr_byte <= '0;
        end else if (accept) begin
            ddr_byte <= wdata[7:0];
        end
    end

`ifdef LC3_DISPLAY_IE_EN
    logic irq_q;

    // IE is the only writable DSR bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie <= 1'b0;
        end else if (wr_en && dsr_hit) begin
            ie <= wdata[IE_BIT];
        end
    end

    // Registered interrupt request, one cycle behind ready and IE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ready & ie;
        end
    end

    assign irq = irq_q;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    // Side-effect-free register read mux.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (dsr_hit) begin
                rdata[READY_BIT] = ready;
                rdata[IE_BIT]    = ie;
            end else if (ddr_hit) begin
                rdata[7:0] = ddr_byte;
            end
        end
    end

endmodule

// File: tb/tb_lc3_display_tx.sv
// tb/tb_lc3_display_tx.sv - self-checking bench for lc3_display_tx at 4 clocks per bit
module tb_lc3_display_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

`ifdef LC3_DISPLAY_IE_EN
    localparam bit IE_BUILD = 1'b1;
`else
    localparam bit IE_BUILD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        wr_en;
    logic [15:0] wdata;
    logic        rd_en;
    logic [15:0] rdata;
    logic        tx;
    logic        irq;

    int n_cmp;
    int n_fail;

    logic [7:0] sb[$];
    bit         mon_en;

    typedef struct {
        logic [15:0] wdata;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[6];

    lc3_display_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wr_en (wr_en),
        .wdata (wdata),
        .rd_en (rd_en),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        addr  = a;
        rd_en = 1'b1;
        #1;
        d     = rdata;
        rd_en = 1'b0;
        addr  = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts cycles after the accept edge until DSR reports ready.
    task automatic wait_ready(output int cnt);
        logic [15:0] d;
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            bus_read(16'hFE04, d);
            if (d[15]) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: ready never rose within 500 cycles");
    endtask

    // Frame decoder: samples mid-bit on falling edges and scores against the queue.
    always begin
        @(negedge clk);
        if (rst_n && mon_en && tx === 1'b0) begin
            logic [7:0] b;
            repeat (2) @(negedge clk);
            check("mon_start_bit", {15'b0, tx}, 16'h0000);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                b[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("mon_stop_bit", {15'b0, tx}, 16'h0001);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL mon_unexpected_frame: got %h expected none", b);
            end else begin
                check("mon_frame_byte", {8'b0, b}, {8'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        logic [15:0] d;
        int          cnt;
        logic [15:0] dsr_idle;

        n_cmp  = 0;
        n_fail = 0;
        mon_en = 1'b1;
        rst_n  = 1'b0;
        addr   = '0;
        wr_en  = 1'b0;
        wdata  = '0;
        rd_en  = 1'b0;

        vecs[0] = '{16'h0041, 8'h41};
        vecs[1] = '{16'h1255, 8'h55};
        vecs[2] = '{16'h00AA, 8'hAA};
        vecs[3] = '{16'h0000, 8'h00};
        vecs[4] = '{16'h00FF, 8'hFF};
        vecs[5] = '{16'h8001, 8'h01};

        // Reset
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("reset_tx", {15'b0, tx}, 16'h0001);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        bus_read(16'hFE04, d);
        check("reset_dsr", d, 16'h8000);
        bus_read(16'hFE06, d);
        check("reset_ddr", d, 16'h0000);
        bus_read(16'h1234, d);
        rd_en = 1'b0;
        check("other_addr_read", d, 16'h0000);

        // Table-driven single characters
        for (int i = 0; i < 6; i++) begin
            bus_write(16'hFE06, vecs[i].wdata);
            sb.push_back(vecs[i].exp_byte);
            check("vec_tx_start", {15'b0, tx}, 16'h0000);
            bus_read(16'hFE04, d);
            check("vec_dsr_busy", d, 16'h0000);
            wait_ready(cnt);
            check("vec_ready_cycles", cnt[15:0], FRAME[15:0]);
            bus_read(16'hFE06, d);
            check("vec_ddr", d, {8'b0, vecs[i].exp_byte});
            tick(2);
        end

        // DDR read without rd_en returns zero
        addr = 16'hFE06;
        #1;
        check("ddr_no_rd_en", rdata, 16'h0000);
        addr = '0;
        tick(1);

        // Busy write is dropped
        bus_write(16'hFE06, 16'h0041);
        sb.push_back(8'h41);
        tick(7);
        bus_write(16'hFE06, 16'h005A);
        wait_ready(cnt);
        check("busy_ready_cycles", cnt[15:0], 16'(FRAME - 8));
        bus_read(16'hFE06, d);
        check("busy_ddr", d, 16'h0041);
        tick(2);

        // Write on the very edge ready rises is dropped
        bus_write(16'hFE06, 16'h0011);
        sb.push_back(8'h11);
        tick(FRAME - 1);
        bus_write(16'hFE06, 16'h0022);
        check("same_edge_tx", {15'b0, tx}, 16'h0001);
        bus_read(16'hFE06, d);
        check("same_edge_ddr", d, 16'h0011);
        tick(2);

        // Back-to-back: second write on the first ready cycle
        bus_write(16'hFE06, 16'h0055);
        sb.push_back(8'h55);
        cnt = 0;
        for (int i = 1; i <= FRAME; i++) begin
            tick(1);
            if (i == 9 * CPB - 1) check("b2b_last_data", {15'b0, tx}, 16'h0000);
            if (i == 9 * CPB)     check("b2b_stop_rise", {15'b0, tx}, 16'h0001);
        end
        bus_read(16'hFE04, d);
        check("b2b_ready", d, 16'h8000);
        bus_write(16'hFE06, 16'h00AA);
        sb.push_back(8'hAA);
        check("b2b_second_start", {15'b0, tx}, 16'h0000);
        wait_ready(cnt);
        check("b2b_ready_cycles", cnt[15:0], FRAME[15:0]);
        tick(2);

        // Reset mid-frame, then a clean frame
        mon_en = 1'b0;
        bus_write(16'hFE06, 16'h0077);
        tick(14);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", {15'b0, tx}, 16'h0001);
        bus_read(16'hFE04, d);
        check("midrst_dsr", d, 16'h8000);
        tick(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(1);
        bus_write(16'hFE06, 16'h0033);
        sb.push_back(8'h33);
        wait_ready(cnt);
        check("midrst_ready_cycles", cnt[15:0], FRAME[15:0]);
        tick(2);

        // Interrupt enable
        dsr_idle = IE_BUILD ? 16'hC000 : 16'h8000;
        bus_write(16'hFE04, 16'h4000);
        check("ie_irq_same_edge", {15'b0, irq}, 16'h0000);
        tick(1);
        check("ie_irq_next", {15'b0, irq}, {15'b0, IE_BUILD});
        bus_read(16'hFE04, d);
        check("ie_dsr", d, dsr_idle);
        bus_write(16'hFE06, 16'h0048);
        sb.push_back(8'h48);
        tick(1);
        check("ie_irq_busy", {15'b0, irq}, 16'h0000);
        cnt = 1;
        while (cnt < FRAME) begin
            tick(1);
            cnt++;
        end
        check("ie_irq_lag", {15'b0, irq}, 16'h0000);
        tick(1);
        check("ie_irq_after_frame", {15'b0, irq}, {15'b0, IE_BUILD});
        bus_write(16'hFE04, 16'h0000);
        tick(2);
        check("ie_irq_cleared", {15'b0, irq}, 16'h0000);
        bus_read(16'hFE04, d);
        check("ie_dsr_cleared", d, 16'h8000);

        tick(4);
        check("sb_drained", 16'(sb.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
